// File: rtl/io_bridge_if.sv
// CPU-side I/O bus for io_bridge: strobes, address, store data and load data.
interface io_bridge_if;
    logic        io_read;
    logic        io_write;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output io_read, io_write, addr, wdata, input rdata);
    modport slave  (input io_read, io_write, addr, wdata, output rdata);
endinterface

// File: rtl/io_bridge.sv
// Memory-mapped bridge between a CPU I/O bus and board peripherals:
// LEDs, switches, a debounced push button and an 8-digit multiplexed hex display.
module io_bridge #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned DB_CYCLES = 200000
) (
    input  logic          clk,
    input  logic          rst_n,
    io_bridge_if.slave    bus,
    input  logic [23:0]   switch,
    input  logic          button,
    output logic [23:0]   led,
    output logic [7:0]    seg_en,
    output logic [7:0]    seg_out
);

    localparam logic [9:0] ADDR_LED_LO = 10'h000;
    localparam logic [9:0] ADDR_LED_HI = 10'h004;
    localparam logic [9:0] ADDR_SWITCH = 10'h010;
    localparam logic [9:0] ADDR_SEG    = 10'h020;
    localparam logic [9:0] ADDR_BTN    = 10'h030;

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    logic [23:0]       sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic              btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              flag_q, flag_d;
    logic [23:0]       led_q, led_d;
    logic [31:0]       seg_q, seg_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        digit_q, digit_d;
    logic [7:0]        seg_en_q, seg_en_d;
    logic [7:0]        seg_out_q, seg_out_d;

    logic wr_led_lo, wr_led_hi, wr_seg, rd_btn;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex digit, dp off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    assign wr_led_lo = bus.io_write && (bus.addr == ADDR_LED_LO);
    assign wr_led_hi = bus.io_write && (bus.addr == ADDR_LED_HI);
    assign wr_seg    = bus.io_write && (bus.addr == ADDR_SEG);
    assign rd_btn    = bus.io_read  && (bus.addr == ADDR_BTN);

    // Load data: purely combinational from the current register state, so a
    // simultaneous store is not visible until the following cycle.
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bus.rdata = '0;
        if (bus.io_read) begin
            case (bus.addr)
                ADDR_SWITCH: bus.rdata = {8'b0, sw_s2_q};
                ADDR_SEG:    bus.rdata = seg_q;
                ADDR_BTN:    bus.rdata = {31'b0, flag_q};
                default:     bus.rdata = '0;
            endcase
        end
    end

    // Synchronizers and CPU-writable registers.
    always_comb begin
        sw_s1_d  = switch;
        sw_s2_d  = sw_s1_q;
        btn_s1_d = button;
        btn_s2_d = btn_s1_q;
        led_d    = led_q;
        seg_d    = seg_q;
        if (wr_led_lo) led_d[15:0]  = bus.wdata[15:0];
        if (wr_led_hi) led_d[23:16] = bus.wdata[7:0];
        if (wr_seg)    seg_d        = bus.wdata;
    end

    // Debouncer: accept a new level after DB_CYCLES consecutive differing cycles;
    // a rising accepted level sets the press flag, which beats a same-cycle clear.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (btn_s2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d = '0;
            level_d  = btn_s2_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
        flag_d = flag_q;
        if (rd_btn)              flag_d = 1'b0;
        if (!level_q && level_d) flag_d = 1'b1;
    end

    // Display scan: the outputs are computed from the next digit index and SEG
    // value so seg_en and seg_out both register on the same edge as the index.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 3'd1;
        end
        seg_en_d  = ~(8'h01 << digit_d);
        seg_out_d = hex_glyph(seg_d[{digit_d, 2'b00} +: 4]);
    end

    // State registers with asynchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            flag_q     <= 1'b0;
            led_q      <= '0;
            seg_q      <= '0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
            seg_en_q   <= 8'hFE;
            seg_out_q  <= 8'hC0;
        end else begin
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            flag_q     <= flag_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            seg_en_q   <= seg_en_d;
            seg_out_q  <= seg_out_d;
        end
    end

    assign led     = led_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_io_bridge.sv
// Directed self-checking bench for io_bridge with SCAN_DIV=4, DB_CYCLES=3.
module tb_io_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] sw = '0;
    logic        btn = 1'b0;
    logic [23:0] led;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int n_checks = 0;
    int n_errors = 0;

    io_bridge_if bus();

    io_bridge #(.SCAN_DIV(4), .DB_CYCLES(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .switch  (sw),
        .button  (btn),
        .led     (led),
        .seg_en  (seg_en),
        .seg_out (seg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock: through the rising edge to the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        bus.addr     = a;
        bus.wdata    = d;
        bus.io_write = 1'b1;
        step();
        bus.io_write = 1'b0;
    endtask

    // Combinational read with no clock edge in between, so no side effects.
    task automatic peek(input string tag, input logic [9:0] a, input logic [31:0] expected);
        bus.io_read = 1'b1;
        bus.addr    = a;
        #1;
        check(tag, bus.rdata, expected);
        bus.io_read = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] prev_en;
        logic [7:0] exp_en;
        logic [7:0] glyphs [8];
        logic [0:9] btn_seq;
        bit         found;

        glyphs  = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        btn_seq = 10'b1011111111;

        bus.io_read  = 1'b0;
        bus.io_write = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;

        // Reset state, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset_led", {8'b0, led}, 32'h0);
        check("reset_seg_en", {24'b0, seg_en}, 32'hFE);
        check("reset_seg_out", {24'b0, seg_out}, 32'hC0);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();

        // LED writes, write-only and read-only addresses.
        bus_write(10'h000, 32'h0000A5A5);
        check("led_lo", {8'b0, led}, 32'h0000A5A5);
        bus_write(10'h004, 32'h000000FF);
        check("led_hi", {8'b0, led}, 32'h00FFA5A5);
        peek("rd_led_wo", 10'h000, 32'h0);
        bus_write(10'h010, 32'hFFFFFFFF);
        check("wr_switch_led", {8'b0, led}, 32'h00FFA5A5);
        peek("wr_switch_rd", 10'h010, 32'h0);
        bus_write(10'h3FC, 32'hFFFFFFFF);
        check("wr_unmapped_led", {8'b0, led}, 32'h00FFA5A5);
        peek("wr_unmapped_seg", 10'h020, 32'h0);

        // Switch synchronizer latency.
        sw = 24'h123456;
        peek("sw_lat0", 10'h010, 32'h0);
        step();
        peek("sw_lat1", 10'h010, 32'h0);
        step();
        peek("sw_lat2", 10'h010, 32'h00123456);
        peek("rd_unmapped", 10'h3FC, 32'h0);
        bus.io_read = 1'b0;
        bus.addr    = 10'h010;
        #1;
        check("rd_no_strobe", bus.rdata, 32'h0);

        // Simultaneous read and write of SEG.
        bus.io_read  = 1'b1;
        bus.io_write = 1'b1;
        bus.addr     = 10'h020;
        bus.wdata    = 32'h89ABCDEF;
        #1;
        check("seg_rw_old", bus.rdata, 32'h0);
        step();
        bus.io_write = 1'b0;
        #1;
        check("seg_rw_new", bus.rdata, 32'h89ABCDEF);
        bus.io_read = 1'b0;

        // Scan sequence: align on the 7F -> FE wrap, then follow all eight digits.
        found   = 1'b0;
        prev_en = seg_en;
        for (int i = 0; i < 64 && !found; i++) begin
            step();
            if (prev_en == 8'h7F && seg_en == 8'hFE) found = 1'b1;
            prev_en = seg_en;
        end
        check("scan_wrap_found", {31'b0, found}, 32'h1);
        for (int i = 0; i < 32; i++) begin
            exp_en = ~(8'h01 << (i / 4));
            check($sformatf("scan_%0d", i), {16'b0, seg_en, seg_out}, {16'b0, exp_en, glyphs[i / 4]});
            step();
        end
        check("scan_rewrap", {24'b0, seg_en}, 32'hFE);

        // Bouncing press while polling BTN every cycle; the set on edge 6
        // coincides with a read and must win, the next read clears it.
        bus.io_read = 1'b1;
        bus.addr    = 10'h030;
        for (int k = 0; k < 10; k++) begin
            btn = btn_seq[k];
            step();
            check($sformatf("btn_flag_%0d", k), bus.rdata, (k == 6) ? 32'h1 : 32'h0);
        end
        bus.io_read = 1'b0;
        btn = 1'b0;
        repeat (8) step();
        peek("btn_release_noflag", 10'h030, 32'h0);

        // Async reset mid-scan with all LEDs on and the flag set.
        bus_write(10'h000, 32'h0000FFFF);
        check("led_all", {8'b0, led}, 32'h00FFFFFF);
        btn = 1'b1;
        repeat (8) step();
        btn = 1'b0;
        peek("flag_before_reset", 10'h030, 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_led", {8'b0, led}, 32'h0);
        check("arst_seg_en", {24'b0, seg_en}, 32'hFE);
        check("arst_seg_out", {24'b0, seg_out}, 32'hC0);
        peek("arst_seg", 10'h020, 32'h0);
        peek("arst_flag", 10'h030, 32'h0);
        peek("arst_switch", 10'h010, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        peek("post_reset_switch", 10'h010, 32'h00123456);
        step();
        check("post_reset_digit0", {24'b0, seg_en}, 32'hFE);
        step();
        check("post_reset_digit1", {24'b0, seg_en}, 32'hFD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles each seven-segment digit is lit; legal range >= 2.
REQ-002 Parameter DB_CYCLES, default 200000, clk cycles the synchronized button must hold a new level before it is accepted; legal range >= 1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 io_read  input  1  CPU I/O load strobe for the current cycle.
REQ-006 io_write  input  1  CPU I/O store strobe for the current cycle.
REQ-007 addr  input  10  low 10 bits of the I/O address; CPU address = 0xFFFFFC00 + addr.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data, combinational from addr, io_read and current register state.
REQ-010 switch  input  24  raw board switches, asynchronous to clk.
REQ-011 button  input  1  raw push button, active-high, bouncing.
REQ-012 led  output  24  LED drive, active-high.
REQ-013 seg_en  output  8  digit enables, active-low, one-hot.
REQ-014 seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-015 Address map: 0x000 LED_LO (wr, bits 15:0), 0x004 LED_HI (wr, bits 7:0 -> led[23:16]), 0x010 SWITCH (rd), 0x020 SEG (rd/wr, 32 bits), 0x030 BTN (rd, bit0 = press flag); all other addresses are unmapped.
REQ-016 A write takes effect at the clk edge that ends a cycle with io_write=1; the new value is visible on led or in the SEG register from the next cycle.
REQ-017 A write to an unmapped or read-only address SHALL change no state.
REQ-018 rdata SHALL be 0 when io_read=0 or addr is unmapped or write-only; otherwise SWITCH returns {8'b0, synchronized switch}, SEG returns the SEG register, and BTN returns {31'b0, flag}.
REQ-019 If io_read and io_write are both 1 in the same cycle, rdata shows the pre-write value and the write still takes effect.
REQ-020 switch passes through a two-flop synchronizer; SWITCH reads reflect the raw input with a 2-cycle latency.
REQ-021 button passes through a two-flop synchronizer and then a debouncer: the counter resets whenever the synchronized value equals the accepted level, and the accepted level takes the synchronized value once the counter reaches DB_CYCLES consecutive differing cycles.
REQ-022 A 0->1 transition of the accepted level sets the press flag.
REQ-023 A cycle with io_read=1 and addr=0x030 clears the flag at the ending edge; if set and clear coincide, set wins.
REQ-024 Scan counter counts 0..SCAN_DIV-1 and then wraps; on the wrap the digit index increments 0..7 and wraps from 7 back to 0.
REQ-025 seg_en bit k is low only when the digit index is k; digit k displays SEG[4k+3:4k] as a hex glyph 0-F with dp off.
REQ-026 The segment outputs and seg_en SHALL be registered so that both change on the same edge, with no glitch between digits.

Reset
REQ-027 While rst_n=0, regardless of clk: led=0, SEG=0, flag=0, accepted level=0, synchronizers=0, counters=0, digit index=0, seg_en=8'hFE, seg_out=8'hC0 (glyph "0").
REQ-028 If reset asserts during a debounce or scan period, the partial count is discarded and counting restarts from 0 after release.

Verification
REQ-029 The test bench SHALL cover each of the following directed scenarios, using SCAN_DIV=4 and DB_CYCLES=3 unless otherwise stated.
REQ-030 Write 0x0000A5A5 to 0x000, then 0x000000FF to 0x004 -> led=0xFFA5A5 after the second edge; a write to 0x010 leaves led and rdata unchanged.
REQ-031 Set switch=0x123456 and wait 2 cycles, then read 0x010 -> rdata=0x00123456; read 0x3FC -> rdata=0; with io_read=0, rdata=0.
REQ-032 Button bounces 1,0,1 on single cycles then holds 1 -> flag sets exactly once, DB_CYCLES cycles after the 1 becomes stable; read 0x030 -> rdata=1, next read -> 0.
REQ-033 Write 0x89ABCDEF to 0x020 -> seg_en steps FE,FD,...,7F, each for 4 cycles, showing F,E,D,C,B,A,9,8 (digit 0 seg_out=0x8E); after 7F it wraps back to FE.
REQ-034 Assert rst_n=0 asynchronously mid-scan with led=0xFFFFFF and flag=1 -> all outputs and state take the REQ-027 values without waiting for a clk edge; a press coinciding with a BTN read leaves flag=1.
